// File: rtl/wave_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wave_capture_ctrl
//  Description : Captures 256 offset-binary samples into the half of a
//                double-buffered sample RAM that the display is not reading.
//                Capture starts on a negative-to-non-negative zero crossing,
//                or is forced after ARM_TIMEOUT samples without one.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_capture_ctrl #(
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    localparam int                 c_ARM_W    = $clog2(ARM_TIMEOUT) + 1;
    localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [c_ARM_W-1:0] c_ARM_ONE  = c_ARM_W'(1);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_prev_sample;
    logic [c_ARM_W-1:0]   r_arm_count;
    logic [c_ARM_W-1:0]   w_arm_count_next;
    logic [7:0]           r_sample_count;
    logic [7:0]           w_sample_count_next;
    logic                 r_read_index;
    logic                 w_read_index_next;
    logic                 w_do_write;
    logic [7:0]           w_index;
    logic                 w_trigger;
    logic [8:0]           r_write_address;
    logic                 r_write_enable;
    logic [7:0]           r_write_sample;

    // Rising zero crossing: previous sample negative, current non-negative.
    assign w_trigger = new_sample_ready & r_prev_sample[15] & ~new_sample_in[15];

    // Next-state, counter and write-request decode.
    always_comb begin
        w_state_next        = r_state;
        w_arm_count_next    = r_arm_count;
        w_sample_count_next = r_sample_count;
        w_read_index_next   = r_read_index;
        w_do_write          = 1'b0;
        w_index             = r_sample_count;
        case (r_state)
            ST_ARMED: begin
                if (new_sample_ready) begin
                    if (w_trigger || (r_arm_count == c_ARM_LAST)) begin
                        w_do_write          = 1'b1;
                        w_index             = 8'd0;
                        w_sample_count_next = 8'd1;
                        w_arm_count_next    = '0;
                        w_state_next        = ST_ACTIVE;
                    end else begin
                        w_arm_count_next = r_arm_count + c_ARM_ONE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    w_do_write          = 1'b1;
                    w_index             = r_sample_count;
                    // Incrementing past 255 wraps to 0 as the capture ends.
                    w_sample_count_next = r_sample_count + 8'd1;
                    if (r_sample_count == 8'hFF) begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Swap buffers only here, so no write is ever in flight.
                if (wave_display_idle) begin
                    w_read_index_next = ~r_read_index;
                    w_arm_count_next  = '0;
                    w_state_next      = ST_ARMED;
                end
            end
            default: begin
                w_arm_count_next = '0;
                w_state_next     = ST_ARMED;
            end
        endcase
    end

    // State, counters, sample history and registered RAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_ARMED;
            r_prev_sample   <= 16'd0;
            r_arm_count     <= '0;
            r_sample_count  <= 8'd0;
            r_read_index    <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= 9'd0;
            r_write_sample  <= 8'd0;
        end else begin
            r_state        <= w_state_next;
            r_arm_count    <= w_arm_count_next;
            r_sample_count <= w_sample_count_next;
            r_read_index   <= w_read_index_next;
            r_write_enable <= w_do_write;
            if (new_sample_ready) begin
                r_prev_sample <= new_sample_in;
            end
            if (w_do_write) begin
                r_write_address <= {~r_read_index, w_index};
                r_write_sample  <= {~new_sample_in[15], new_sample_in[14:8]};
            end
        end
    end

    assign write_address = r_write_address;
    assign write_enable  = r_write_enable;
    assign write_sample  = r_write_sample;
    assign read_index    = r_read_index;

endmodule
`default_nettype wire
